// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types for the round-robin shared-counter arbiter.
package shared_reg_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_READ  = 2'b00,
    OP_INC   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr, with wrap.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  localparam int unsigned N = N_REQ;

  always_comb begin
    any = |req;
    idx = '0;
    // Walk offsets from farthest to nearest so the nearest set bit is written last.
    for (int unsigned k = N; k > 0; k--) begin
      int unsigned j;
      j = ((k - 1) + 32'(ptr)) % N;
      if (req[j]) idx = IDX_W'(j);
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// One WIDTH-bit counter shared by N_REQ requesters; round-robin grant, one op per two cycles.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [OP_W*N_REQ-1:0]    req_op,
  input  logic [WIDTH*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         cnt_value
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

  state_e           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] w_id;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  op_e              sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] next_val;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    sel_op   = OP_READ;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_op   = op_e'(req_op[OP_W*i +: OP_W]);
        sel_data = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    next_val = cnt_value;
    case (op_q)
      OP_READ:  next_val = cnt_value;
      OP_INC:   next_val = cnt_value + WIDTH'(1);
      OP_LOAD:  next_val = data_q;
      OP_CLEAR: next_val = '0;
      default:  next_val = cnt_value;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      w_id      <= '0;
      op_q      <= OP_READ;
      data_q    <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      cnt_value <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= 1'b0;
          if (pick_any) begin
            w_id   <= pick_idx;
            op_q   <= sel_op;
            data_q <= sel_data;
            gnt    <= N_REQ'(1) << pick_idx;
            rr_ptr <= (pick_idx == LAST) ? '0 : pick_idx + IDX_W'(1);
            state  <= S_EXEC;
          end else begin
            gnt <= '0;
          end
        end
        S_EXEC: begin
          cnt_value <= next_val;
          rsp_valid <= 1'b1;
          rsp_id    <= w_id;
          rsp_data  <= next_val;
          gnt       <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N_REQ=4, WIDTH=8).
module tb_shared_reg_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic [7:0]  cnt_value;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] READ = 2'b00, INC = 2'b01, LOAD = 2'b10, CLEAR = 2'b11;

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_op    (req_op),
    .req_data  (req_data),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .cnt_value (cnt_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] d);
    req[id]             = 1'b1;
    req_op[2*id +: 2]   = op;
    req_data[8*id +: 8] = d;
  endtask

  // Single-requester op; optionally corrupt op/data during the gnt cycle.
  task automatic do_op(input string tag, input int id, input logic [1:0] op,
                       input logic [7:0] d, input logic [7:0] exp, input bit flip);
    req = '0;
    set_req(id, op, d);
    step();
    chk({tag, ".gnt"}, 32'(gnt), 32'(4'b0001 << id));
    chk({tag, ".rsp_valid_at_gnt"}, 32'(rsp_valid), 0);
    req[id] = 1'b0;
    if (flip) begin
      req_op[2*id +: 2]   = CLEAR;
      req_data[8*id +: 8] = ~d;
    end
    step();
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 1);
    chk({tag, ".rsp_id"}, 32'(rsp_id), 32'(id));
    chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp));
    chk({tag, ".cnt_value"}, 32'(cnt_value), 32'(exp));
    chk({tag, ".gnt_at_rsp"}, 32'(gnt), 0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_op   = '0;
    req_data = '0;
    do_reset();

    chk("reset.gnt", 32'(gnt), 0);
    chk("reset.rsp_valid", 32'(rsp_valid), 0);
    chk("reset.rsp_id", 32'(rsp_id), 0);
    chk("reset.rsp_data", 32'(rsp_data), 0);
    chk("reset.cnt_value", 32'(cnt_value), 0);

    // 1. Single INC from requester 2
    do_op("single", 2, INC, 8'h00, 8'h01, 1'b0);

    // 2. Contention: all four hold INC; order 0,1,2,3,0 from a fresh pointer
    do_reset();
    req    = 4'b1111;
    req_op = {INC, INC, INC, INC};
    for (int k = 0; k < 5; k++) begin
      step();
      chk("contend.gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      chk("contend.no_rsp", 32'(rsp_valid), 0);
      step();
      chk("contend.rsp_valid", 32'(rsp_valid), 1);
      chk("contend.rsp_id", 32'(rsp_id), 32'(k % 4));
      chk("contend.rsp_data", 32'(rsp_data), 32'(k + 1));
      chk("contend.gnt_low", 32'(gnt), 0);
    end
    req = '0;
    step();
    chk("contend.idle_gnt", 32'(gnt), 0);
    chk("contend.idle_rsp", 32'(rsp_valid), 0);
    chk("contend.hold_cnt", 32'(cnt_value), 5);

    // 3. Wrap-around
    do_op("wrap.load", 1, LOAD, 8'hFE, 8'hFE, 1'b0);
    do_op("wrap.inc1", 3, INC, 8'h00, 8'hFF, 1'b0);
    do_op("wrap.inc2", 3, INC, 8'h00, 8'h00, 1'b0);

    // 4. Mixed ops pending together; pointer is at 0 after requester 3
    req = '0;
    set_req(0, LOAD, 8'h5A);
    set_req(1, READ, 8'h77);
    step();
    chk("mixed.gnt0", 32'(gnt), 32'b0001);
    req[0] = 1'b0;
    step();
    chk("mixed.rsp0_valid", 32'(rsp_valid), 1);
    chk("mixed.rsp0_id", 32'(rsp_id), 0);
    chk("mixed.rsp0_data", 32'(rsp_data), 32'h5A);
    step();
    chk("mixed.gnt1", 32'(gnt), 32'b0010);
    req[1] = 1'b0;
    step();
    chk("mixed.rsp1_id", 32'(rsp_id), 1);
    chk("mixed.rsp1_data", 32'(rsp_data), 32'h5A);
    do_op("mixed.clear", 2, CLEAR, 8'h00, 8'h00, 1'b0);
    do_op("mixed.load", 1, LOAD, 8'h44, 8'h44, 1'b0);

    // 5. Reset during EXEC aborts the LOAD; pointer returns to 0
    req = '0;
    set_req(0, LOAD, 8'h33);
    step();
    chk("rst_exec.gnt", 32'(gnt), 32'b0001);
    req   = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_exec.no_rsp", 32'(rsp_valid), 0);
    chk("rst_exec.cnt", 32'(cnt_value), 0);
    chk("rst_exec.gnt", 32'(gnt), 0);
    step();
    chk("rst_exec.still_no_rsp", 32'(rsp_valid), 0);
    chk("rst_exec.cnt_hold", 32'(cnt_value), 0);
    set_req(0, READ, 8'h00);
    set_req(3, INC, 8'h00);
    step();
    chk("rst_exec.prio0", 32'(gnt), 32'b0001);
    req = '0;
    step();
    chk("rst_exec.read_data", 32'(rsp_data), 0);
    do_op("rst_exec.req3", 3, INC, 8'h00, 8'h01, 1'b0);

    // 6. Op flipped to CLEAR during gnt cycle: INC result still returned
    do_op("late_op", 1, INC, 8'h00, 8'h02, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
